dmem_arbiter: RTL and testbench

Shares the single data-memory port between two requesters: port 0, the memory stage's store/load path (address from the ALU result, data and byte strobes from the store-lane formatter), and port 1, a secondary master such as a debug/DMA unit. It arbitrates, latches the winning request, holds it on the memory bus until acknowledged or timed out, and returns a one-cycle completion with read data. It sits between the pipeline's memory stage and the data memory and is the sole driver of the memory port.

---
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grants one requester, holds the access on the memory
// bus until mem_ack or timeout, then returns a one-cycle done. Round-robin ties: DMEM_ARB_RR_EN.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        r0_req_i,
  input  logic        r0_we_i,
  input  logic [31:0] r0_addr_i,
  input  logic [31:0] r0_wdata_i,
  input  logic [3:0]  r0_width_i,
  output logic        r0_gnt_o,
  output logic        r0_done_o,

  input  logic        r1_req_i,
  input  logic        r1_we_i,
  input  logic [31:0] r1_addr_i,
  input  logic [31:0] r1_wdata_i,
  input  logic [3:0]  r1_width_i,
  output logic        r1_gnt_o,
  output logic        r1_done_o,

  output logic [31:0] rdata_o,
  output logic        err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_width_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q;
  logic        owner_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [7:0]  cnt_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_width_q;
`ifdef DMEM_ARB_RR_EN
  logic        last_q;
`endif

  logic        win;
  logic        grant;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_width;

  // win = 0 selects port 0, 1 selects port 1
  always_comb begin
    win = 1'b0;
    if (r0_req_i && r1_req_i) begin
`ifdef DMEM_ARB_RR_EN
      win = ~last_q;
`else
      win = 1'b0;
`endif
    end else if (r1_req_i) begin
      win = 1'b1;
    end
  end

  // Gated by reset so no grant is seen while the block is held in reset.
  assign grant    = rst_ni && (state_q == StIdle) && (r0_req_i || r1_req_i);
  assign r0_gnt_o = grant & ~win;
  assign r1_gnt_o = grant & win;

  assign sel_we    = win ? r1_we_i    : r0_we_i;
  assign sel_addr  = win ? r1_addr_i  : r0_addr_i;
  assign sel_wdata = win ? r1_wdata_i : r0_wdata_i;
  assign sel_width = win ? r1_width_i : r0_width_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_width_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (grant) begin
            state_q     <= StWait;
            owner_q     <= win;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_width_q <= sel_width;
`ifdef DMEM_ARB_RR_EN
            last_q      <= win;
`endif
          end
        end
        StWait: begin
          // An ack in the final allowed cycle takes precedence over the timeout.
          if (mem_ack_i) begin
            state_q   <= StDone;
            mem_req_q <= 1'b0;
            rdata_q   <= mem_rdata_i;
            err_q     <= 1'b0;
            done_q    <= 1'b1;
          end else if (cnt_q >= TimeoutLast) begin
            state_q   <= StDone;
            mem_req_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b1;
            done_q    <= 1'b1;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign r0_done_o   = done_q & ~owner_q;
  assign r1_done_o   = done_q & owner_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_width_o = mem_width_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected completions go into a queue at grant time
// and a negedge monitor pops and compares them whenever a done pulse appears.
module tb_dmem_arbiter;

  localparam int unsigned Tmo = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_width, r1_width;
  logic        r0_gnt, r1_gnt, r0_done, r1_done;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_width;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  logic exp_last = 1'b1;

  dmem_arbiter #(.TIMEOUT(Tmo)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
    .r0_width_i(r0_width), .r0_gnt_o(r0_gnt), .r0_done_o(r0_done),
    .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
    .r1_width_i(r1_width), .r1_gnt_o(r1_gnt), .r1_done_o(r1_done),
    .rdata_o(rdata), .err_o(err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_width_o(mem_width), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && (r0_done || r1_done)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: got r0=%b r1=%b expected none", r0_done, r1_done);
      end else begin
        e = exp_q.pop_front();
        chk("done_r0", {31'b0, r0_done}, {31'b0, e.port == 0});
        chk("done_r1", {31'b0, r1_done}, {31'b0, e.port == 1});
        chk("done_rdata", rdata, e.rdata);
        chk("done_err", {31'b0, err}, {31'b0, e.err});
      end
    end
  end

  function automatic logic model_win(input logic q0, input logic q1);
    if (q0 && q1) begin
`ifdef DMEM_ARB_RR_EN
      return ~exp_last;
`else
      return 1'b0;
`endif
    end
    return q1;
  endfunction

  // Single-requester transaction. ack_cyc = 0 means no ack (timeout).
  task automatic txn(input int port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] width,
                     input int ack_cyc, input logic [31:0] rdat, input logic ack_in_done);
    int   last_c;
    exp_t x;
    if (port == 0) begin
      r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_width = width;
    end else begin
      r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_width = width;
    end
    #1;
    chk("gnt0", {31'b0, r0_gnt}, {31'b0, port == 0});
    chk("gnt1", {31'b0, r1_gnt}, {31'b0, port == 1});
    exp_last = (port == 1);
    x.port  = port;
    x.rdata = (ack_cyc == 0) ? 32'h0 : rdat;
    x.err   = (ack_cyc == 0);
    exp_q.push_back(x);
    cyc();
    r0_req = 0; r1_req = 0;
    r0_addr = ~addr; r1_addr = ~addr; r0_wdata = 32'h5555_AAAA; r1_wdata = 32'h3333_CCCC;
    r0_width = ~width; r1_width = ~width; r0_we = ~we; r1_we = ~we;
    last_c = (ack_cyc == 0) ? Tmo : ack_cyc;
    for (int c = 1; c <= last_c; c++) begin
      mem_ack   = (c == ack_cyc);
      mem_rdata = (c == ack_cyc) ? rdat : (32'hBAD0_0000 + c);
      #1;
      chk("mem_req_wait", {31'b0, mem_req}, 32'd1);
      chk("mem_we", {31'b0, mem_we}, {31'b0, we});
      chk("mem_addr", mem_addr, addr);
      chk("mem_wdata", mem_wdata, wdata);
      chk("mem_width", {28'b0, mem_width}, {28'b0, width});
      cyc();
    end
    // DONE cycle: other port requests but must not be granted.
    mem_ack   = ack_in_done;
    mem_rdata = 32'hFEED_F00D;
    if (port == 0) r1_req = 1; else r0_req = 1;
    #1;
    chk("mem_req_done", {31'b0, mem_req}, 32'd0);
    chk("no_gnt_done", {30'b0, r1_gnt, r0_gnt}, 32'd0);
    cyc();
    r0_req = 0; r1_req = 0; mem_ack = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; r0_req = 1; r1_req = 0; r0_we = 0; r1_we = 0;
    r0_addr = 0; r1_addr = 0; r0_wdata = 0; r1_wdata = 0; r0_width = 0; r1_width = 0;
    mem_ack = 0; mem_rdata = 0;
    cyc();
    cyc();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_width", {28'b0, mem_width}, 32'd0);
    chk("rst_done", {30'b0, r1_done, r0_done}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_gnt", {30'b0, r1_gnt, r0_gnt}, 32'd0);
    r0_req = 0;
    rst_n = 1;
    cyc();

    txn(0, 1'b1, 32'h100, 32'h0000_AB00, 4'b0010, 2, 32'h5A5A_0000, 1'b0);
    txn(1, 1'b0, 32'h40, 32'h0, 4'b1111, 1, 32'hDEAD_BEEF, 1'b0);
    txn(0, 1'b0, 32'h200, 32'h0, 4'b1111, 0, 32'h0, 1'b0);
    txn(1, 1'b0, 32'h204, 32'h0, 4'b1100, Tmo, 32'h0BAD_CAFE, 1'b0);

    // Spurious ack in IDLE, then a transaction with ack also high during DONE.
    mem_ack = 1; mem_rdata = 32'h1111_2222;
    #1;
    chk("spur_idle_req", {31'b0, mem_req}, 32'd0);
    cyc();
    chk("spur_idle_req2", {31'b0, mem_req}, 32'd0);
    mem_ack = 0;
    cyc();
    txn(0, 1'b0, 32'h300, 32'h0, 4'b0001, 1, 32'h0000_0077, 1'b1);
    txn(1, 1'b1, 32'h304, 32'hCAFE_0000, 4'b1000, 3, 32'h0, 1'b0);

    // Reset in cycle 2 of WAIT: mem_req drops immediately, transaction lost.
    r0_req = 1; r0_we = 1; r0_addr = 32'h400; r0_wdata = 32'h1; r0_width = 4'b0001;
    #1;
    chk("pre_rst_gnt0", {31'b0, r0_gnt}, 32'd1);
    cyc();
    r0_req = 0;
    chk("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
    cyc();
    rst_n = 0; r0_req = 1; r1_req = 1;
    exp_last = 1'b1;
    #1;
    chk("rst_wait_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_wait_gnt", {30'b0, r1_gnt, r0_gnt}, 32'd0);
    cyc();
    rst_n = 1;

    // Both request continuously for four transactions.
    for (int t = 0; t < 4; t++) begin
      logic w;
      exp_t x;
      w = model_win(1'b1, 1'b1);
      #1;
      chk("tie_gnt0", {31'b0, r0_gnt}, {31'b0, ~w});
      chk("tie_gnt1", {31'b0, r1_gnt}, {31'b0, w});
      exp_last = w;
      x.port = int'(w); x.rdata = 32'h1000 + t; x.err = 1'b0;
      exp_q.push_back(x);
      cyc();
      mem_ack = 1; mem_rdata = 32'h1000 + t;
      #1;
      chk("tie_wait_gnt", {30'b0, r1_gnt, r0_gnt}, 32'd0);
      cyc();
      mem_ack = 0;
      if (t == 3) begin
        r0_req = 0; r1_req = 0;
      end
      #1;
      chk("tie_done_gnt", {30'b0, r1_gnt, r0_gnt}, 32'd0);
      cyc();
    end

    cyc();
    cyc();
    chk("pending_expected", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
